// File: rtl/uart_gen.sv
// UART transmitter with command FIFO and a mid-bit-sampling receiver.
// Optional parity generation and checking is enabled by defining UART_PARITY_EN.
module uart_gen #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cmd_in,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              rx,
  output logic              tx,
  output logic              read_rdy,
  output logic [DATA_W-1:0] read_data,
  output logic              rx_err,
  output logic              tx_busy
);

  localparam int unsigned PTR_W  = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned TXC_W  = $clog2(STOP_BITS * CLK_DIV);
  localparam int unsigned RXC_W  = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  localparam logic [TXC_W-1:0]  TX_BIT_END  = TXC_W'(CLK_DIV - 1);
  localparam logic [TXC_W-1:0]  TX_STOP_END = TXC_W'(STOP_BITS * CLK_DIV - 1);
  localparam logic [RXC_W-1:0]  RX_HALF     = RXC_W'(CLK_DIV / 2 - 1);
  localparam logic [RXC_W-1:0]  RX_FULL     = RXC_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(TX_DEPTH);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---------------- TX command FIFO ----------------
  logic [DATA_W-1:0] r_mem [TX_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_fcnt;

  tx_state_t         r_tx_state;
  logic [TXC_W-1:0]  r_tx_cnt;
  logic [BIT_W-1:0]  r_tx_bit;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx;
`ifdef UART_PARITY_EN
  logic              r_tx_par;
`endif

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_unused;

  assign w_fifo_full  = (r_fcnt == FIFO_FULL);
  assign w_fifo_empty = (r_fcnt == '0);
  assign w_push       = cmd_vld && !w_fifo_full && cmd_in[8];
  assign w_pop        = !w_fifo_empty &&
                        ((r_tx_state == TX_IDLE) ||
                         (r_tx_state == TX_STOP && r_tx_cnt == TX_STOP_END));
  assign w_fifo_dout  = r_mem[r_rd_ptr];
  assign w_unused     = ^{cmd_in, PARITY_ODD};

  assign cmd_rdy = !w_fifo_full;
  assign tx_busy = !w_fifo_empty || (r_tx_state != TX_IDLE);
  assign tx      = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + FCNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - FCNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // ---------------- TX frame FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_tx_shift <= w_fifo_dout;
`ifdef UART_PARITY_EN
            r_tx_par   <= (^w_fifo_dout) ^ 1'(PARITY_ODD);
`endif
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == TX_BIT_END) begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + TXC_W'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == TX_BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_tx       <= r_tx_par;
              r_tx_state <= TX_PARITY;
`else
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
              r_tx_bit   <= r_tx_bit + BIT_W'(1);
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + TXC_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (r_tx_cnt == TX_BIT_END) begin
            r_tx       <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + TXC_W'(1);
          end
        end
`endif
        TX_STOP: begin
          // A queued word starts its start bit right after the last stop cycle
          if (r_tx_cnt == TX_STOP_END) begin
            r_tx_cnt <= '0;
            if (w_pop) begin
              r_tx_shift <= w_fifo_dout;
`ifdef UART_PARITY_EN
              r_tx_par   <= (^w_fifo_dout) ^ 1'(PARITY_ODD);
`endif
              r_tx       <= 1'b0;
              r_tx_state <= TX_START;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + TXC_W'(1);
          end
        end
        default: begin
          r_tx       <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic              r_rx_s1;
  logic              r_rx_s2;
  rx_state_t         r_rx_state;
  logic [RXC_W-1:0]  r_rx_cnt;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_read_data;
  logic              r_read_rdy;
  logic              r_rx_err;
`ifdef UART_PARITY_EN
  logic              r_rx_perr;
`endif
  logic              w_rx;

  assign w_rx      = r_rx_s2;
  assign read_data = r_read_data;
  assign read_rdy  = r_read_rdy;
  assign rx_err    = r_rx_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_read_data <= '0;
      r_read_rdy  <= 1'b0;
      r_rx_err    <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_perr   <= 1'b0;
`endif
    end else begin
      r_read_rdy <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Re-check the start bit mid-way; a high level here was a glitch
          if (r_rx_cnt == RX_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + RXC_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == RX_FULL) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[DATA_W-1:1]};
            if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + BIT_W'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + RXC_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (r_rx_cnt == RX_FULL) begin
            r_rx_cnt   <= '0;
            r_rx_perr  <= w_rx ^ (^r_rx_shift) ^ 1'(PARITY_ODD);
            r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + RXC_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (r_rx_cnt == RX_FULL) begin
            r_rx_cnt <= '0;
            if (!w_rx) begin
              r_rx_err   <= 1'b1;
              r_rx_state <= RX_WAIT_HIGH;
`ifdef UART_PARITY_EN
            end else if (r_rx_perr) begin
              r_rx_err   <= 1'b1;
              r_rx_state <= RX_IDLE;
`endif
            end else begin
              r_read_data <= r_rx_shift;
              r_read_rdy  <= 1'b1;
              r_rx_state  <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + RXC_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (w_rx) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_gen.sv
// Randomized self-checking bench for uart_gen: TX waveform and RX results are
// compared against frames built arithmetically from the bytes that were sent.
module tb_uart_gen;

  localparam int unsigned CLK_DIV   = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned TX_DEPTH  = 4;
  localparam int unsigned STOP_BITS = 1;
`ifdef UART_PARITY_EN
  localparam int unsigned PAR_BITS  = 1;
`else
  localparam int unsigned PAR_BITS  = 0;
`endif
  localparam int unsigned FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int unsigned FRAME_CYC  = FRAME_BITS * CLK_DIV;

  logic        clk;
  logic        rst;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        rx;
  logic        tx;
  logic        read_rdy;
  logic [7:0]  read_data;
  logic        rx_err;
  logic        tx_busy;
  logic        loop_en;
  logic        rx_drv;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          tx_log [65536];
  logic [7:0]  rd_q [$];
  int          err_cnt = 0;
  logic [7:0]  exp_last;

  assign rx = loop_en ? tx : rx_drv;

  uart_gen #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH),
    .STOP_BITS(STOP_BITS), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .rx(rx), .tx(tx), .read_rdy(read_rdy), .read_data(read_data),
    .rx_err(rx_err), .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < 65536) tx_log[cyc] = tx;
    if (!rst) begin
      if (read_rdy) rd_q.push_back(read_data);
      if (rx_err) err_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Line bits of one frame, LSB = first bit on the wire
  function automatic logic [15:0] frame_word(input logic [7:0] d);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < int'(DATA_W); i++) f[1+i] = d[i];
`ifdef UART_PARITY_EN
    f[1+DATA_W] = 1'($countones(d) % 2);
`endif
    return f;
  endfunction

  task automatic send_burst(input logic [15:0] cmds[$], input bit stop_on_full,
                            output int n_acc, output int first_cyc,
                            output logic [7:0] pushed[$]);
    int idx;
    int guard;
    pushed = {};
    n_acc = 0;
    first_cyc = -1;
    idx = 0;
    guard = 0;
    while (idx < cmds.size() && guard < 200) begin
      @(negedge clk);
      guard++;
      if (stop_on_full && !cmd_rdy) break;
      cmd_in  = cmds[idx];
      cmd_vld = 1'b1;
      if (cmd_rdy) begin
        n_acc++;
        if (cmds[idx][8]) begin
          pushed.push_back(cmds[idx][7:0]);
          if (first_cyc < 0) first_cyc = cyc;
        end
        idx++;
      end
    end
    if (guard >= 200) check_eq("burst_timeout", 32'(idx), 32'(cmds.size()));
    @(negedge clk);
    cmd_vld = 1'b0;
    cmd_in  = '0;
  endtask

  task automatic check_frames(input int first_cyc, input logic [7:0] bytes[$]);
    int start;
    int base;
    int glitches;
    int zeros;
    logic [15:0] obs;
    start = first_cyc + 2;
    check_eq("tx_pre_idle", 32'(tx_log[start-1]), 32'd1);
    for (int k = 0; k < bytes.size(); k++) begin
      base = start + k * int'(FRAME_CYC);
      obs = '1;
      glitches = 0;
      for (int b = 0; b < int'(FRAME_BITS); b++) begin
        obs[b] = tx_log[base + b * int'(CLK_DIV)];
        for (int c = 0; c < int'(CLK_DIV); c++)
          if (tx_log[base + b * int'(CLK_DIV) + c] != obs[b]) glitches++;
      end
      check_eq("tx_frame", 32'(obs), 32'(frame_word(bytes[k])));
      check_eq("tx_bit_width", 32'(glitches), 32'd0);
    end
    zeros = 0;
    base = start + bytes.size() * int'(FRAME_CYC);
    for (int c = 0; c < 16; c++) if (!tx_log[base + c]) zeros++;
    check_eq("tx_post_idle", 32'(zeros), 32'd0);
  endtask

  task automatic check_rx(input logic [7:0] bytes[$], input int err_before);
    check_eq("rx_count", 32'(rd_q.size()), 32'(bytes.size()));
    for (int i = 0; i < bytes.size() && i < rd_q.size(); i++)
      check_eq("rx_data", 32'(rd_q[i]), 32'(bytes[i]));
    check_eq("rx_no_err", 32'(err_cnt - err_before), 32'd0);
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par_bad, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < int'(DATA_W); i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
    drive_bit((^d) ^ par_bad);
`else
    if (par_bad) drive_bit(1'b1);
`endif
    drive_bit(stop_v);
  endtask

  initial begin
    logic [15:0] cmds[$];
    logic [7:0]  pushed[$];
    logic [7:0]  exp_bytes[$];
    int          n_acc;
    int          first_cyc;
    int          e0;
    int          bad;
    logic [7:0]  b;

    rst = 1'b1; cmd_vld = 1'b0; cmd_in = '0; loop_en = 1'b1; rx_drv = 1'b1;
    exp_last = 8'h00;
    wait_cyc(3);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("rst_read_rdy", 32'(read_rdy), 32'd0);
    check_eq("rst_read_data", 32'(read_data), 32'd0);
    check_eq("rst_rx_err", 32'(rx_err), 32'd0);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(4);

    // Single frame 0xA5 through loopback
    rd_q.delete(); e0 = err_cnt;
    cmds = {16'h01A5};
    send_burst(cmds, 1'b0, n_acc, first_cyc, pushed);
    wait_cyc(FRAME_CYC + 40);
    exp_bytes = {8'hA5};
    check_frames(first_cyc, exp_bytes);
    check_rx(exp_bytes, e0);
    check_eq("idle_busy", 32'(tx_busy), 32'd0);
    exp_last = 8'hA5;

    // Hold valid until the FIFO fills
    rd_q.delete(); e0 = err_cnt;
    cmds = {16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106};
    send_burst(cmds, 1'b1, n_acc, first_cyc, pushed);
    check_eq("full_accepts", 32'(n_acc), 32'd5);
    exp_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    wait_cyc(5 * FRAME_CYC + 40);
    check_frames(first_cyc, exp_bytes);
    check_rx(exp_bytes, e0);
    exp_last = 8'h05;

    // Non-transmit command is consumed silently
    rd_q.delete();
    cmds = {16'h0055};
    send_burst(cmds, 1'b0, n_acc, first_cyc, pushed);
    check_eq("discard_accept", 32'(n_acc), 32'd1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!tx || tx_busy) bad++;
    end
    #1;
    check_eq("discard_quiet", 32'(bad), 32'd0);
    check_eq("discard_no_rx", 32'(rd_q.size()), 32'd0);

    // Random bursts mixing transmit and discard commands
    for (int it = 0; it < 6; it++) begin
      int n;
      rd_q.delete(); e0 = err_cnt;
      n = int'($urandom_range(1, 5));
      cmds = {};
      for (int i = 0; i < n; i++)
        cmds.push_back({7'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom)});
      send_burst(cmds, 1'b0, n_acc, first_cyc, pushed);
      check_eq("rand_accepts", 32'(n_acc), 32'(n));
      wait_cyc(pushed.size() * FRAME_CYC + 40);
      if (pushed.size() > 0) begin
        check_frames(first_cyc, pushed);
        exp_last = pushed[pushed.size()-1];
      end
      check_rx(pushed, e0);
      check_eq("rand_busy_done", 32'(tx_busy), 32'd0);
    end

    // Directly driven RX: glitch, then framing error, then a good frame
    loop_en = 1'b0; rx_drv = 1'b1;
    rd_q.delete(); e0 = err_cnt;
    @(negedge clk); rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    wait_cyc(40);
    check_eq("glitch_no_rdy", 32'(rd_q.size()), 32'd0);
    check_eq("glitch_no_err", 32'(err_cnt - e0), 32'd0);

    drive_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx_drv = 1'b1;
    wait_cyc(20);
    check_eq("frame_err", 32'(err_cnt - e0), 32'd1);
    check_eq("frame_err_no_rdy", 32'(rd_q.size()), 32'd0);
    check_eq("frame_err_keep", 32'(read_data), 32'(exp_last));

    rd_q.delete(); e0 = err_cnt;
    b = 8'($urandom);
    drive_frame(b, 1'b0, 1'b1);
    wait_cyc(20);
    exp_bytes = {b};
    check_rx(exp_bytes, e0);
    check_eq("good_read_data", 32'(read_data), 32'(b));
    exp_last = b;

`ifdef UART_PARITY_EN
    rd_q.delete(); e0 = err_cnt;
    drive_frame(8'h03, 1'b1, 1'b1);
    wait_cyc(20);
    check_eq("par_err", 32'(err_cnt - e0), 32'd1);
    check_eq("par_err_no_rdy", 32'(rd_q.size()), 32'd0);
    check_eq("par_err_keep", 32'(read_data), 32'(exp_last));
    rd_q.delete(); e0 = err_cnt;
    drive_frame(8'h03, 1'b0, 1'b1);
    wait_cyc(20);
    exp_bytes = {8'h03};
    check_rx(exp_bytes, e0);
    exp_last = 8'h03;
`endif

    // Reset in the middle of a looped-back frame
    loop_en = 1'b1;
    cmds = {16'h01C3};
    send_burst(cmds, 1'b0, n_acc, first_cyc, pushed);
    wait_cyc(30);
    rst = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_busy", 32'(tx_busy), 32'd0);
    check_eq("midrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check_eq("midrst_read_data", 32'(read_data), 32'd0);
    wait_cyc(2);
    rd_q.delete(); e0 = err_cnt;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(FRAME_CYC + 40);
    check_eq("midrst_no_rdy", 32'(rd_q.size()), 32'd0);
    check_eq("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check_eq("midrst_tx_idle", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
